serial_addsub: RTL and testbench

Parametrised, multi-cycle adder/subtractor built from a chain of `DIGIT` full-adder cells that is reused over `WIDTH/DIGIT` beats, with a carry register between beats. It trades latency for area against a flat `WIDTH`-bit ripple adder. It sits in datapaths where an add/sub result is needed once per operation rather than every cycle. It uses a start/busy/done handshake and reports carry-out and signed overflow.

---
 rtl/serial_addsub.sv | 124 ++++++++++++
 tb/tb_serial_addsub.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: a DIGIT-bit full-adder chain reused over WIDTH/DIGIT beats
// with a carry register between beats and a start/busy/done handshake.
module serial_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, a_sr_next;
  logic [WIDTH-1:0] b_sr, b_sr_next;
  logic [WIDTH-1:0] res_sr, res_sr_next;
  logic             carry, carry_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next, ovf_next, busy_next, done_next;

  logic [DIGIT-1:0] chain_sum;
  logic             chain_cout;
  logic             chain_top_cin;

  // DIGIT chained full-adder cells on the low bits of the operand shift registers
  always_comb begin
    logic cc;
    cc            = carry;
    chain_sum     = '0;
    chain_top_cin = 1'b0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      if (i == int'(DIGIT) - 1) chain_top_cin = cc;
      chain_sum[i] = a_sr[i] ^ b_sr[i] ^ cc;
      cc           = (a_sr[i] & b_sr[i]) | (cc & (a_sr[i] ^ b_sr[i]));
    end
    chain_cout = cc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    a_sr_next   = a_sr;
    b_sr_next   = b_sr;
    res_sr_next = res_sr;
    carry_next  = carry;
    cnt_next    = cnt;
    sum_next    = sum;
    cout_next   = cout;
    ovf_next    = ovf;
    case (state)
      IDLE: begin
        if (start) begin
          a_sr_next  = a;
          b_sr_next  = sub ? ~b : b;
          carry_next = sub ? 1'b1 : cin;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        a_sr_next   = a_sr >> DIGIT;
        b_sr_next   = b_sr >> DIGIT;
        res_sr_next = WIDTH'({chain_sum, res_sr} >> DIGIT);
        carry_next  = chain_cout;
        cnt_next    = cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          sum_next   = res_sr_next;
          cout_next  = chain_cout;
          ovf_next   = chain_top_cin ^ chain_cout;
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      a_sr   <= a_sr_next;
      b_sr   <= b_sr_next;
      res_sr <= res_sr_next;
      carry  <= carry_next;
      cnt    <= cnt_next;
      sum    <= sum_next;
      cout   <= cout_next;
      ovf    <= ovf_next;
      busy   <= busy_next;
      done   <= done_next;
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and randomised checks of serial_addsub in 8x1 and 16x4 configurations.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       n_start, n_sub, n_cin, n_busy, n_done, n_cout, n_ovf;
  logic [7:0] n_a, n_b, n_sum;
  logic        w_start, w_sub, w_cin, w_busy, w_done, w_cout, w_ovf;
  logic [15:0] w_a, w_b, w_sum;

  int total = 0;
  int bad   = 0;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut_n (
    .clk(clk), .rst_n(rst_n), .start(n_start), .sub(n_sub), .cin(n_cin),
    .a(n_a), .b(n_b), .busy(n_busy), .done(n_done), .sum(n_sum),
    .cout(n_cout), .ovf(n_ovf)
  );

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(w_start), .sub(w_sub), .cin(w_cin),
    .a(w_a), .b(w_b), .busy(w_busy), .done(w_done), .sum(w_sum),
    .cout(w_cout), .ovf(w_ovf)
  );

  // Launch one 8-bit op from IDLE; returns latency and busy-cycle count, ends back in IDLE.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin,
                     output int lat, output int bcnt);
    n_a = a; n_b = b; n_sub = sub; n_cin = cin; n_start = 1'b1;
    @(negedge clk);
    n_start = 1'b0;
    lat = 0; bcnt = 0;
    while (n_done !== 1'b1 && lat < 40) begin
      if (n_busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic cin,
                      output int lat);
    w_a = a; w_b = b; w_sub = sub; w_cin = cin; w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    lat = 0;
    while (w_done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    n_start = 0; n_sub = 0; n_cin = 0; n_a = '0; n_b = '0;
    w_start = 0; w_sub = 0; w_cin = 0; w_a = '0; w_b = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({n_busy, n_done, n_sum, n_cout, n_ovf} !== 12'h0) begin
      bad++;
      $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               n_busy, n_done, n_sum, n_cout, n_ovf);
    end
    total++;
    if ({w_busy, w_done, w_sum, w_cout, w_ovf} !== 20'h0) begin
      bad++;
      $display("FAIL reset16: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               w_busy, w_done, w_sum, w_cout, w_ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_add;
    int lat, bcnt;
    op8(8'h3C, 8'h05, 1'b0, 1'b0, lat, bcnt);
    total++;
    if (lat !== 8) begin bad++; $display("FAIL add_latency: got %0d want 8", lat); end
    total++;
    if (bcnt !== 8) begin bad++; $display("FAIL add_busy_cycles: got %0d want 8", bcnt); end
    total++;
    if ({n_sum, n_cout, n_ovf} !== {8'h41, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL add_result: sum=%h cout=%b ovf=%b want 41 0 0", n_sum, n_cout, n_ovf);
    end
  endtask

  task automatic test_carry_chain;
    int lat, bcnt;
    op8(8'hFF, 8'h01, 1'b0, 1'b1, lat, bcnt);
    total++;
    if ({n_sum, n_cout, n_ovf} !== {8'h01, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL carry_ff: sum=%h cout=%b ovf=%b want 01 1 0", n_sum, n_cout, n_ovf);
    end
    op8(8'h7F, 8'h01, 1'b0, 1'b0, lat, bcnt);
    total++;
    if ({n_sum, n_cout, n_ovf} !== {8'h80, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL carry_7f: sum=%h cout=%b ovf=%b want 80 0 1", n_sum, n_cout, n_ovf);
    end
  endtask

  task automatic test_subtract;
    int lat, bcnt;
    op8(8'h80, 8'h01, 1'b1, 1'b1, lat, bcnt);
    total++;
    if ({n_sum, n_cout, n_ovf} !== {8'h7F, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL sub_80: sum=%h cout=%b ovf=%b want 7f 1 1", n_sum, n_cout, n_ovf);
    end
    op8(8'h05, 8'h07, 1'b1, 1'b0, lat, bcnt);
    total++;
    if ({n_sum, n_cout, n_ovf} !== {8'hFE, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL sub_05: sum=%h cout=%b ovf=%b want fe 0 0", n_sum, n_cout, n_ovf);
    end
  endtask

  task automatic test_handshake;
    int lat;
    n_a = 8'h12; n_b = 8'h34; n_sub = 1'b0; n_cin = 1'b0; n_start = 1'b1;
    @(negedge clk);
    n_start = 1'b0;
    repeat (2) @(negedge clk);
    n_a = 8'hFF; n_b = 8'hFF; n_sub = 1'b1; n_cin = 1'b1; n_start = 1'b1;
    @(negedge clk);
    n_start = 1'b0;
    lat = 3;
    while (n_done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 8) begin bad++; $display("FAIL hs_latency: got %0d want 8", lat); end
    n_start = 1'b1;
    total++;
    if (n_sum !== 8'h46) begin bad++; $display("FAIL hs_result: sum=%h want 46", n_sum); end
    @(negedge clk);
    n_start = 1'b0;
    total++;
    if (n_busy !== 1'b0) begin bad++; $display("FAIL hs_done_start: busy=%b want 0", n_busy); end
    repeat (5) @(negedge clk);
    total++;
    if ({n_sum, n_done, n_busy} !== {8'h46, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL hs_hold: sum=%h done=%b busy=%b want 46 0 0", n_sum, n_done, n_busy);
    end
  endtask

  task automatic test_back_to_back;
    int t, t1, t2;
    n_a = 8'h01; n_b = 8'h02; n_sub = 1'b0; n_cin = 1'b0; n_start = 1'b1;
    t = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && t < 60) begin
      @(negedge clk);
      t++;
      if (n_done === 1'b1) begin
        if (t1 < 0) t1 = t;
        else        t2 = t;
      end
    end
    n_start = 1'b0;
    total++;
    if (t2 - t1 !== 10 || t1 < 0) begin
      bad++;
      $display("FAIL b2b_interval: got %0d want 10", t2 - t1);
    end
    total++;
    if (n_sum !== 8'h03) begin bad++; $display("FAIL b2b_result: sum=%h want 03", n_sum); end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat, bcnt, seen;
    n_a = 8'hAA; n_b = 8'h11; n_sub = 1'b0; n_cin = 1'b0; n_start = 1'b1;
    @(negedge clk);
    n_start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({n_busy, n_done, n_sum, n_cout, n_ovf} !== 12'h0) begin
      bad++;
      $display("FAIL rst_mid: busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               n_busy, n_done, n_sum, n_cout, n_ovf);
    end
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (n_done === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL rst_no_done: pulses=%0d want 0", seen); end
    op8(8'h10, 8'h20, 1'b0, 1'b0, lat, bcnt);
    total++;
    if (n_sum !== 8'h30) begin bad++; $display("FAIL rst_fresh: sum=%h want 30", n_sum); end
  endtask

  task automatic test_wide_digit;
    int lat;
    logic [15:0] ra, rb, bb, esum;
    logic        rs, rc, ec, eo;
    logic [16:0] full;
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL wide_latency: got %0d want 4", lat); end
    total++;
    if ({w_sum, w_cout, w_ovf} !== {16'h0000, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL wide_result: sum=%h cout=%b ovf=%b want 0000 1 0", w_sum, w_cout, w_ovf);
    end
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      bb   = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, bb} + 17'(rs ? 1'b1 : rc);
      esum = full[15:0];
      ec   = full[16];
      eo   = (ra[15] == bb[15]) && (esum[15] != ra[15]);
      op16(ra, rb, rs, rc, lat);
      total++;
      if ({w_sum, w_cout, w_ovf} !== {esum, ec, eo}) begin
        bad++;
        $display("FAIL wide_rand%0d: a=%h b=%h sub=%b cin=%b got %h %b %b want %h %b %b",
                 i, ra, rb, rs, rc, w_sum, w_cout, w_ovf, esum, ec, eo);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic_add;
    test_carry_chain;
    test_subtract;
    test_handshake;
    test_back_to_back;
    test_reset_mid;
    test_wide_digit;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
